sweep_scheduler: RTL
====================

# sweep_scheduler

Sequencer that drives the lock-in acquisition chain through a frequency sweep. It steps a 32-bit frequency tuning word from a start value by a fixed increment and holds each point for a programmable settle time. It then asserts `ADC_acquire` for a programmable number of ADC samples. It runs in the `clk_adc` domain, feeds the NCO/waveform generator (`freq_word`) and the data processor (`ADC_acquire`), and supports both the discontinuous (settle between points) and continuous sweep modes.

## Interface
Parameters:
- `FREQ_BITS`, 32: width of the frequency tuning word.
- `CNT_BITS`, 16: width of the point, settle and acquire counters.

Ports:
- `clk_adc` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; starts a sweep when idle.
- `abort` in 1: level; stops the sweep.
- `mode_nCont_disc` in 1: 0 = continuous, 1 = discontinuous.
- `freq_start` in FREQ_BITS: first tuning word.
- `freq_step` in FREQ_BITS: increment per point, two's complement.
- `n_points` in CNT_BITS: number of sweep points.
- `settle_cycles` in CNT_BITS: settle length in cycles.
- `acquire_cycles` in CNT_BITS: acquire length per point; 0 is treated as 1.
- `freq_word` out FREQ_BITS: current tuning word to the NCO.
- `ADC_acquire` out 1: acquisition window to the data processor.
- `point_index` out CNT_BITS: index of the current point.
- `busy` out 1: high from the cycle after an accepted start until the block returns to IDLE.
- `done` out 1: one-cycle pulse when the sweep completes.

## Operation
- State machine: IDLE, SETTLE, ACQUIRE, DONE.
- IDLE
  - `start`=1 with `n_points`!=0 is accepted.
  - On acceptance, latch all configuration inputs, load `freq_word`=`freq_start` and `point_index`=0, then go to SETTLE.
  - `start` with `n_points`=0 is ignored: stay in IDLE, no `done`.
- SETTLE
  - Lasts `settle_cycles` cycles with `ADC_acquire`=0.
  - If `settle_cycles`=0, SETTLE lasts 1 cycle; the minimum gap is one cycle.
  - Then go to ACQUIRE.
- ACQUIRE
  - Lasts max(`acquire_cycles`,1) cycles with `ADC_acquire`=1.
  - If the last cycle belongs to the last point (`point_index`=`n_points`-1), go to DONE.
  - Otherwise update on the transition: `freq_word` += `freq_step` (modulo 2^FREQ_BITS, wrap-around allowed) and `point_index` += 1.
  - Discontinuous mode: return to SETTLE.
  - Continuous mode: stay in ACQUIRE and restart the acquire counter. `ADC_acquire` stays 1 across the point boundary, with no settle after the first point.
- DONE
  - One cycle: `done`=1, `ADC_acquire`=0, `busy`=1.
  - Then go to IDLE with `busy`=0.
- `freq_word` and `point_index` hold their last values in IDLE until the next accepted `start`.
- `abort`
  - Sampled in every state; it takes priority over all transitions.
  - Next cycle: state=IDLE, `ADC_acquire`=0, `busy`=0, no `done`.
  - `freq_word` and `point_index` freeze.
  - `abort` and `start` together in IDLE: `abort` wins and the sweep does not start.
- `start` while `busy` is ignored.
- Configuration input changes while busy have no effect, because the values were latched at start.
- All outputs are registered.

## Timing
- Reset value of every output is 0 (`freq_word`, `point_index`, `ADC_acquire`, `busy`, `done`).
- A `reset` mid-sweep returns the block to IDLE on the next edge, with all outputs 0.
- Start latency, with `start` high at edge t:
  - At t+1: `busy`=1, `freq_word`=`freq_start`, state=SETTLE.
  - `ADC_acquire` first rises at t+1+max(S,1).
- Discontinuous sweep, with S=`settle_cycles` and A=max(`acquire_cycles`,1):
  - Each point occupies max(S,1)+A cycles.
  - The `done` pulse follows the last acquire cycle by 1 cycle.
  - `busy` lasts N·(max(S,1)+A)+1 cycles.
- Continuous sweep:
  - `busy` lasts max(S,1)+N·A+1 cycles.
  - `ADC_acquire` is high for N·A consecutive cycles.
- `freq_word` changes on the same edge on which the new point's first cycle starts.
- In discontinuous mode, the data processor detects the frequency change while `ADC_acquire` is low.

## Test plan
- Discontinuous basic: `freq_start`=1000, `freq_step`=100, N=3, S=4, A=8, mode=1.
  - `freq_word` = 1000, 1100, 1200.
  - Three 8-cycle `ADC_acquire` windows, each preceded by 4 low cycles.
  - `done` 1 cycle after the last window; `busy` high for 37 cycles.
- Continuous: same values with mode=0.
  - `ADC_acquire` high for 24 consecutive cycles.
  - `freq_word` steps every 8 cycles.
  - `busy` high for 29 cycles.
- Edge configuration: S=0, A=0, N=1.
  - Acquire rises at t+2 and lasts 1 cycle; `done` at t+3.
  - Separately, `start` with N=0: no `busy`, no `done`.
- Wrap-around: `freq_start`=0xFFFFFFF0, `freq_step`=0x20, N=2.
  - Second point `freq_word`=0x00000010.
  - Negative step: `freq_step`=0xFFFFFF9C (−100) from 1000 gives 900.
- Abort mid-ACQUIRE of point 1 (N=4):
  - Next cycle: IDLE, `ADC_acquire`=0, `busy`=0, no `done`, `point_index` frozen at 1.
  - A subsequent `start` restarts at `point_index`=0.
- Reset mid-SETTLE, plus `start` pulses while busy:
  - Reset: all outputs 0 next cycle.
  - `start` pulses while busy: no restart, and the sequence is identical to an unperturbed run.

Source files
------------

// File: rtl/sweep_scheduler.sv
// Frequency sweep sequencer: steps the NCO tuning word and gates
// the ADC acquisition window with settle/acquire timing per point.
module sweep_scheduler #(
  parameter int FREQ_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk_adc,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode_nCont_disc,
  input  logic [FREQ_BITS-1:0] freq_start,
  input  logic [FREQ_BITS-1:0] freq_step,
  input  logic [CNT_BITS-1:0]  n_points,
  input  logic [CNT_BITS-1:0]  settle_cycles,
  input  logic [CNT_BITS-1:0]  acquire_cycles,
  output logic [FREQ_BITS-1:0] freq_word,
  output logic                 ADC_acquire,
  output logic [CNT_BITS-1:0]  point_index,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE, SETTLE, ACQUIRE, DONE
  } state_t;

  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  state_t state_q, state_d;

  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [CNT_BITS-1:0]  point_q, point_d;
  logic [FREQ_BITS-1:0] freq_q, freq_d;

  logic [FREQ_BITS-1:0] step_q;
  logic [CNT_BITS-1:0]  n_q, s_q, a_q;
  logic                 disc_q;
  logic                 load;

  logic acq_q, acq_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic settle_last, acq_last, last_pt;

  // Zero-length settle/acquire collapse to a single cycle
  assign settle_last = (s_q == '0) || (cnt_q == s_q - ONE);
  assign acq_last    = (a_q == '0) || (cnt_q == a_q - ONE);
  assign last_pt     = (point_q == n_q - ONE);

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      point_q <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      n_q     <= '0;
      s_q     <= '0;
      a_q     <= '0;
      disc_q  <= 1'b0;
      acq_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      point_q <= point_d;
      freq_q  <= freq_d;
      acq_q   <= acq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        step_q <= freq_step;
        n_q    <= n_points;
        s_q    <= settle_cycles;
        a_q    <= acquire_cycles;
        disc_q <= mode_nCont_disc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    point_d = point_q;
    freq_d  = freq_q;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (n_points != '0)) begin
            load    = 1'b1;
            state_d = SETTLE;
            cnt_d   = '0;
            freq_d  = freq_start;
            point_d = '0;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ACQUIRE: begin
          if (acq_last) begin
            cnt_d = '0;
            if (last_pt) begin
              state_d = DONE;
            end else begin
              freq_d  = freq_q + step_q;
              point_d = point_q + ONE;
              state_d = disc_q ? SETTLE : ACQUIRE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Flags are decoded from the next state so they land in registers
  always_comb begin
    acq_d  = (state_d == ACQUIRE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign freq_word   = freq_q;
  assign point_index = point_q;
  assign ADC_acquire = acq_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
